riscv_run_monitor: RTL

- Synthesizable run-control and register-dump unit that wraps the riscv core for bench and FPGA bring-up.
- Holds the core in reset for a fixed cycle count, then lets it run for a cycle budget.
- Freezes the core and streams a parametrised window of architectural registers over a valid/ready channel.
- Replaces hierarchical register peeks with a port-level debug read path.

---
 rtl/riscv_run_monitor_pkg.sv | 26 ++
 rtl/riscv_run_monitor_sat_counter.sv | 43 ++++
 rtl/riscv_run_monitor.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_run_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_monitor_pkg
// Description : Shared types and constants for the riscv run monitor.
//               XLEN_DEFAULT  default register/PC width
//               REG_ADDR_W    architectural register index width
//               EBREAK_INSN   encoding of the EBREAK instruction
//               monitor_state_t  run-control / dump state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_run_monitor_pkg;

    localparam int          XLEN_DEFAULT = 64;
    localparam int          REG_ADDR_W   = 5;
    localparam logic [31:0] EBREAK_INSN  = 32'h0010_0073;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        RUN    = 3'd1,
        LOAD   = 3'd2,
        STREAM = 3'd3,
        DONE   = 3'd4
    } monitor_state_t;

endpackage : riscv_run_monitor_pkg
`default_nettype wire

// File: rtl/riscv_run_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_monitor_sat_counter
// Description : Up-counter that stops at TC_VALUE and flags it.
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-high reset, count -> 0
//   en     in  count up (ignored once the terminal count is reached)
//   clr    in  synchronous clear, wins over en
//   count  out current count
//   tc     out high while count == TC_VALUE
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_monitor_sat_counter #(
    parameter int WIDTH    = 4,
    parameter int TC_VALUE = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_tc = WIDTH'(TC_VALUE);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && !tc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tc    = (r_count == c_tc);
    assign count = r_count;

endmodule : riscv_run_monitor_sat_counter
`default_nettype wire

// File: rtl/riscv_run_monitor.sv
`default_nettype none
// ============================================================================
// Module      : riscv_run_monitor
// Description : Run control and register dump for the riscv core. Holds the
//               core in reset, runs it for a cycle budget, then freezes it
//               and streams registers FIRST_REG..FIRST_REG+NUM_REGS-1 over a
//               valid/ready channel using the core's debug read port.
//   clk, reset          clock / asynchronous active-high reset
//   cpu_reset, cpu_halt core reset and freeze controls
//   pc_in, instr_in     core PC and current instruction
//   dbg_reg_addr/data   register-file debug read path
//   out_valid/ready     dump handshake; out_data, out_index payload
//   final_pc            PC latched at end of run
//   done, timed_out     dump complete / run ended by budget
// Optional    : RISCV_RUN_MONITOR_HALT_DETECT_EN enables EBREAK and
//               stuck-PC halt detection during RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_run_monitor
    import riscv_run_monitor_pkg::*;
#(
    parameter int XLEN         = XLEN_DEFAULT,
    parameter int FIRST_REG    = 5,
    parameter int NUM_REGS     = 9,
    parameter int RESET_CYCLES = 2,
    parameter int RUN_CYCLES   = 30,
    parameter int HALT_STABLE  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  cpu_reset,
    output logic                  cpu_halt,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [31:0]           instr_in,
    output logic [REG_ADDR_W-1:0] dbg_reg_addr,
    input  logic [XLEN-1:0]       dbg_reg_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_data,
    output logic [REG_ADDR_W-1:0] out_index,
    output logic [XLEN-1:0]       final_pc,
    output logic                  done,
    output logic                  timed_out
);

    localparam int c_hold_w = $clog2(RESET_CYCLES + 1);
    localparam int c_run_w  = $clog2(RUN_CYCLES + 1);

    if (FIRST_REG < 0 || NUM_REGS < 1 || FIRST_REG + NUM_REGS > 32) begin : g_bad_window
        $error("riscv_run_monitor: register window exceeds x0..x31");
    end
    if (RESET_CYCLES < 1 || RUN_CYCLES < 1 || HALT_STABLE < 1) begin : g_bad_counts
        $error("riscv_run_monitor: cycle counts must be at least 1");
    end

    monitor_state_t        r_state, w_state_next;
    logic [REG_ADDR_W-1:0] r_idx;
    logic                  r_out_valid;
    logic [XLEN-1:0]       r_out_data;
    logic [REG_ADDR_W-1:0] r_out_index;
    logic [XLEN-1:0]       r_final_pc;

    logic [c_hold_w-1:0]   w_hold_cnt;
    logic                  w_hold_tc;
    logic [c_run_w-1:0]    w_run_cnt;
    logic                  w_run_tc;
    logic                  w_budget;
    logic                  w_halt;
    logic                  w_xfer;
    logic                  w_last;
    logic                  w_unused;

    riscv_run_monitor_sat_counter #(
        .WIDTH    (c_hold_w),
        .TC_VALUE (RESET_CYCLES - 1)
    ) u_hold_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == HOLD),
        .clr   (1'b0),
        .count (w_hold_cnt),
        .tc    (w_hold_tc)
    );

    riscv_run_monitor_sat_counter #(
        .WIDTH    (c_run_w),
        .TC_VALUE (RUN_CYCLES - 1)
    ) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (r_state == RUN),
        .clr   (r_state != RUN),
        .count (w_run_cnt),
        .tc    (w_run_tc)
    );

    assign w_budget = (r_state == RUN) && w_run_tc;

`ifdef RISCV_RUN_MONITOR_HALT_DETECT_EN
    localparam int c_stable_w = $clog2(HALT_STABLE + 1);

    logic [XLEN-1:0]       r_prev_pc;
    logic                  r_timed_out;
    logic                  w_armed;
    logic                  w_same;
    logic [c_stable_w-1:0] w_stable_cnt;
    logic                  w_stable_tc;

    // The first RUN cycle has no valid previous PC, so detection waits a cycle.
    assign w_armed = (r_state == RUN) && (w_run_cnt != '0);
    assign w_same  = w_armed && (pc_in == r_prev_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_pc <= '0;
        end else begin
            r_prev_pc <= pc_in;
        end
    end

    // Counts consecutive unchanged-PC edges; halt fires on the HALT_STABLE-th.
    riscv_run_monitor_sat_counter #(
        .WIDTH    (c_stable_w),
        .TC_VALUE (HALT_STABLE - 1)
    ) u_stable_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (w_same),
        .clr   (!w_same),
        .count (w_stable_cnt),
        .tc    (w_stable_tc)
    );

    assign w_halt = w_armed && ((instr_in == EBREAK_INSN) || (w_same && w_stable_tc));

    // A halt on the budget edge still counts as a halt, not a timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timed_out <= 1'b0;
        end else if (w_budget || w_halt) begin
            r_timed_out <= !w_halt;
        end
    end

    assign timed_out = r_timed_out;
    assign w_unused  = ^{w_hold_cnt, w_stable_cnt};
`else
    assign w_halt    = 1'b0;
    assign timed_out = 1'b0;
    assign w_unused  = ^{w_hold_cnt, w_run_cnt, instr_in};
`endif

    assign w_xfer = r_out_valid && out_ready;
    assign w_last = (r_idx == REG_ADDR_W'(NUM_REGS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            HOLD:    if (w_hold_tc) w_state_next = RUN;
            RUN:     if (w_halt || w_budget) w_state_next = LOAD;
            LOAD:    w_state_next = STREAM;
            STREAM:  if (w_xfer) w_state_next = w_last ? DONE : LOAD;
            DONE:    w_state_next = DONE;
            default: w_state_next = HOLD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_index <= '0;
            r_final_pc  <= '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt || w_budget) begin
                        r_final_pc <= pc_in;
                    end
                end
                LOAD: begin
                    r_out_data  <= dbg_reg_data;
                    r_out_index <= dbg_reg_addr;
                    r_out_valid <= 1'b1;
                end
                STREAM: begin
                    if (w_xfer) begin
                        r_out_valid <= 1'b0;
                        if (!w_last) begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_reset    = (r_state == HOLD);
    assign cpu_halt     = (r_state == LOAD) || (r_state == STREAM) || (r_state == DONE);
    assign done         = (r_state == DONE);
    assign dbg_reg_addr = REG_ADDR_W'(FIRST_REG) + r_idx;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_index    = r_out_index;
    assign final_pc     = r_final_pc;

endmodule : riscv_run_monitor
`default_nettype wire
